hazard_scoreboard: RTL
======================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NREG, default 32: number of architectural registers tracked; register 0 is never tracked.
REQ-002 Parameter RW, default 5: register-index width, RW = clog2(NREG).
REQ-003 Parameter ALU_LAT, default 1: pending count loaded for a non-load producer.
REQ-004 Parameter LOAD_LAT, default 2: pending count loaded for a load producer.
REQ-005 Parameter FWD_SLACK, default 1: highest pending count the EX forwarding paths can cover.
REQ-006 Parameter CW, default 2: counter width; CW SHALL hold max(ALU_LAT, LOAD_LAT).
REQ-007 clock  in  1  sole clock, rising edge.
REQ-008 reset  in  1  asynchronous, active-high.
REQ-009 id_valid  in  1  valid instruction in IF/ID.
REQ-010 id_rs, id_rt  in  RW each  source register indices.
REQ-011 id_use_rs, id_use_rt  in  1 each  source actually read.
REQ-012 id_branch  in  1  instruction resolves in ID (BEQ class); it needs operands with no forwarding.
REQ-013 id_wr_en  in  1  instruction writes a register.
REQ-014 id_wr_reg  in  RW  destination index.
REQ-015 id_load  in  1  producer is a load (LW class).
REQ-016 flush  in  1  squash the IF/ID instruction this cycle.
REQ-017 stall  out  1  hold PC and IF/ID, inject bubble into ID/EX.
REQ-018 pending  out  NREG  bit r = counter r nonzero; bit 0 always 0.

Function
REQ-019 Block SHALL hold one CW-bit counter per register 1..NREG-1.
REQ-020 Source hazard on rs: id_use_rs and id_rs != 0 and cnt[id_rs] > (id_branch ? 0 : FWD_SLACK); rt identical.
REQ-021 stall SHALL be combinational: id_valid and not flush and (rs hazard or rt hazard).
REQ-022 Issue event SHALL be id_valid and not stall and not flush.
REQ-023 Each cycle every nonzero counter SHALL decrement by 1, independent of stall.
REQ-024 On issue with id_wr_en and id_wr_reg != 0, cnt[id_wr_reg] SHALL load max(L, cnt[id_wr_reg] - 1) where L = id_load ? LOAD_LAT : ALU_LAT; this load overrides that counter's decrement.
REQ-025 Issue writing register 0 SHALL leave all counters unchanged.
REQ-026 Instruction reading its own destination SHALL be checked against pre-issue counters (no self-hazard).
REQ-027 flush SHALL force stall low and block issue; counters of older in-flight producers SHALL keep decrementing.
REQ-028 Resulting latencies at defaults: ALU->ALU 0 stall cycles, LW->use 1, ALU->branch 1, LW->branch 2.
REQ-029 pending SHALL reflect registered counters only (no same-cycle issue visibility).

Reset
REQ-030 reset high SHALL asynchronously clear all counters; pending = 0, and stall = 0 for any input while reset is high.
REQ-031 Reset asserted mid-stall SHALL drop stall immediately; the first cycle after deassertion SHALL see an empty scoreboard.

Configuration
REQ-032 Macro HAZARD_STALL_CNT_EN SHALL add output stall_count (16 bits): counts cycles with stall = 1, saturates at 16'hFFFF, cleared by reset.
REQ-033 Without HAZARD_STALL_CNT_EN the port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-034 Issue LW r8, next cycle ADD reads r8 -> stall = 1 for exactly 1 cycle, ADD issues on the 2nd cycle.
REQ-035 Issue ADD r9, next cycle BEQ reads r9 -> stall 1 cycle; repeat with LW r9 -> stall 2 cycles.
REQ-036 Issue ADD r3 then ADD reading r3 -> stall never asserted; pending[3] = 1 for 1 cycle.
REQ-037 LW r0 then ADD reading r0 -> no stall; pending = 0 throughout.
REQ-038 LW r5, consumer stalled, flush = 1 -> stall = 0 that cycle, no issue, pending[5] clears 2 cycles after the LW issued; with HAZARD_STALL_CNT_EN, stall_count does not increment on the flush cycle.
REQ-039 Reset asserted during a 2-cycle load-branch stall -> stall falls immediately, pending = 0, stall_count = 0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Per-register pending-write scoreboard for an in-order pipeline. Each
//   tracked register holds a small down-counter loaded when a producer issues
//   from ID; a consumer in ID stalls while the producer's remaining latency
//   exceeds what forwarding can cover. Branches resolve in ID and read the
//   register file directly, so they stall on any nonzero count.
//
//   Optional feature: define HAZARD_STALL_CNT_EN to add stall_count, a
//   saturating 16-bit count of stalled cycles.
//
// Ports
//   clock                    rising-edge clock
//   reset                    asynchronous active-high reset
//   id_valid                 instruction present in IF/ID
//   id_rs, id_rt             source register indices
//   id_use_rs, id_use_rt     source is actually read
//   id_branch                instruction resolves in ID (no forwarding)
//   id_wr_en, id_wr_reg      destination write enable / index
//   id_load                  producer is a load
//   flush                    squash the IF/ID instruction this cycle
//   stall                    hold PC and IF/ID, bubble into ID/EX
//   pending                  bit r set while counter r is nonzero
//   stall_count              (HAZARD_STALL_CNT_EN only) stalled-cycle count

// One register's remaining-latency counter. It always counts down toward
// zero; a load strobe replaces the decremented value with the larger of the
// new latency and what is left of the older producer.
module hazard_reg_cnt #(
    parameter int CW = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ld,
    input  logic [CW-1:0] ld_val,
    output logic [CW-1:0] cnt_q
);
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] dec;

    always_comb begin
        dec   = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
        cnt_d = dec;
        if (ld) begin
            cnt_d = (ld_val > dec) ? ld_val : dec;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

module hazard_scoreboard #(
    parameter int NREG      = 32,
    parameter int RW        = 5,
    parameter int ALU_LAT   = 1,
    parameter int LOAD_LAT  = 2,
    parameter int FWD_SLACK = 1,
    parameter int CW        = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [RW-1:0]   id_rs,
    input  logic [RW-1:0]   id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic            id_branch,
    input  logic            id_wr_en,
    input  logic [RW-1:0]   id_wr_reg,
    input  logic            id_load,
    input  logic            flush,
    output logic            stall,
    output logic [NREG-1:0] pending
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [15:0]     stall_count
`endif
);
    localparam logic [CW-1:0] ALU_L  = CW'(ALU_LAT);
    localparam logic [CW-1:0] LOAD_L = CW'(LOAD_LAT);

    // Slot 0 is a constant zero so r0 never looks busy and indexing stays simple.
    logic [NREG-1:0][CW-1:0] cnt_all;
    logic [CW-1:0]           rs_cnt, rt_cnt;
    logic [31:0]             thr;
    logic                    rs_haz, rt_haz;
    logic                    wr_fire;
    logic [CW-1:0]           ld_val;

    assign cnt_all[0] = '0;

    always_comb begin
        rs_cnt = (32'(id_rs) < NREG) ? cnt_all[id_rs] : '0;
        rt_cnt = (32'(id_rt) < NREG) ? cnt_all[id_rt] : '0;
        // ID-resolved branches get no forwarding: any outstanding write hazards.
        thr    = id_branch ? 32'd0 : 32'(FWD_SLACK);
        rs_haz = id_use_rs && (id_rs != '0) && (32'(rs_cnt) > thr);
        rt_haz = id_use_rt && (id_rt != '0) && (32'(rt_cnt) > thr);
        // Hazards use the registered counters only, so an instruction that
        // reads its own destination never sees its own write.
        stall  = !reset && id_valid && !flush && (rs_haz || rt_haz);
        wr_fire = id_valid && !stall && !flush && id_wr_en && (id_wr_reg != '0);
        ld_val  = id_load ? LOAD_L : ALU_L;
    end

    for (genvar g = 1; g < NREG; g++) begin : g_reg
        hazard_reg_cnt #(.CW(CW)) u_cnt (
            .clock  (clock),
            .reset  (reset),
            .ld     (wr_fire && (id_wr_reg == RW'(g))),
            .ld_val (ld_val),
            .cnt_q  (cnt_all[g])
        );
    end

    always_comb begin
        pending = '0;
        for (int r = 1; r < NREG; r++) begin
            pending[r] = |cnt_all[r];
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [15:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) stall_count_q <= '0;
        else       stall_count_q <= stall_count_d;
    end

    assign stall_count = stall_count_q;
`else
    // No stall statistics in this build.
`endif
endmodule
